lum_sensor_filter: RTL and testbench

- Upstream conditioning stage for the external-lights controller.
- Takes raw 8-bit ambient-light ADC samples with a valid strobe and block-averages them over a window of 2^LOG2_WIN samples.
- Drives the averaged brightness Lum_sen, a per-update strobe, a hysteresis Dark flag and a sensor-timeout fault.
- Lum_sen feeds the external-lights block directly, so its brightness input never sees raw sensor noise.

---
 rtl/lum_pkg.sv | 17 +
 rtl/lum_sensor_filter_if.sv | 32 +++
 rtl/lum_window_avg.sv | 72 +++++++
 rtl/lum_sensor_filter.sv | 94 +++++++++
 tb/tb_lum_sensor_filter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/lum_pkg.sv
// Shared constants and FSM encoding for the ambient-light
// conditioning path and the external-lights block.
package lum_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int LOG2_WIN_DEF  = 3;
  localparam int DARK_TH_DEF   = 40;
  localparam int BRIGHT_TH_DEF = 60;
  localparam int TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_BRIGHT = 2'd1,
    ST_DARK   = 2'd2
  } lum_state_e;

endpackage

// File: rtl/lum_sensor_filter_if.sv
// Sensor-side bundle: raw ADC samples in, filtered
// brightness, dark flag and fault out.
interface lum_sensor_filter_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] Adc_data;
  logic              Adc_valid;
  logic [DATA_W-1:0] Lum_sen;
  logic              Lum_valid;
  logic              Dark;
  logic              Sensor_fault;

  modport master (
    output Adc_data,
    output Adc_valid,
    input  Lum_sen,
    input  Lum_valid,
    input  Dark,
    input  Sensor_fault
  );

  modport slave (
    input  Adc_data,
    input  Adc_valid,
    output Lum_sen,
    output Lum_valid,
    output Dark,
    output Sensor_fault
  );

endinterface

// File: rtl/lum_window_avg.sv
// Block average over 2^LOG2_WIN samples with a one-cycle
// update strobe and a clear for discarding a partial window.
module lum_window_avg
  import lum_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              done_o,
  output logic [DATA_W-1:0] avg_o,
  output logic [DATA_W-1:0] lum_o,
  output logic              lum_valid_o
);

  localparam int ACC_W = DATA_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_MAX = '1;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   lum_q, lum_d;
  logic                lv_q, lv_d;
  logic [ACC_W-1:0]    sum;
  logic                done;

  always_comb begin
    sum   = acc_q + ACC_W'(data_i);
    done  = valid_i && (cnt_q == CNT_MAX);
    acc_d = acc_q;
    cnt_d = cnt_q;
    lum_d = lum_q;
    lv_d  = 1'b0;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (valid_i) begin
      if (done) begin
        acc_d = '0;
        cnt_d = '0;
        lum_d = sum[ACC_W-1:LOG2_WIN];
        lv_d  = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      lum_q <= '0;
      lv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      lum_q <= lum_d;
      lv_q  <= lv_d;
    end
  end

  assign done_o      = done;
  assign avg_o       = sum[ACC_W-1:LOG2_WIN];
  assign lum_o       = lum_q;
  assign lum_valid_o = lv_q;

endmodule

// File: rtl/lum_sensor_filter.sv
// Averaged ambient brightness with a hysteresis dark flag
// and a sensor-timeout fault that forces lights on.
module lum_sensor_filter
  import lum_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LOG2_WIN  = LOG2_WIN_DEF,
  parameter int DARK_TH   = DARK_TH_DEF,
  parameter int BRIGHT_TH = BRIGHT_TH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input logic CLK,
  input logic Reset,
  lum_sensor_filter_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] DARK_LVL = DATA_W'(DARK_TH);
  localparam logic [DATA_W-1:0] BRT_LVL  = DATA_W'(BRIGHT_TH);

  lum_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              fault_q, fault_d;
  logic              dark_q, dark_d;
  logic              timeout_hit;
  logic              win_done;
  logic [DATA_W-1:0] win_avg;

  lum_window_avg #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_avg (
    .clk         (CLK),
    .rst_n       (Reset),
    .clr_i       (timeout_hit),
    .valid_i     (bus.Adc_valid),
    .data_i      (bus.Adc_data),
    .done_o      (win_done),
    .avg_o       (win_avg),
    .lum_o       (bus.Lum_sen),
    .lum_valid_o (bus.Lum_valid)
  );

  always_comb begin
    idle_d      = idle_q;
    fault_d     = fault_q;
    state_d     = state_q;
    timeout_hit = 1'b0;
    if (bus.Adc_valid) begin
      idle_d  = '0;
      fault_d = 1'b0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
    // a valid sample always beats the timeout
    if (!bus.Adc_valid && idle_d == IDLE_MAX) begin
      timeout_hit = 1'b1;
      fault_d     = 1'b1;
      state_d     = ST_DARK;
    end
    if (win_done) begin
      unique case (state_q)
        ST_INIT:
          state_d = (win_avg <= DARK_LVL) ? ST_DARK : ST_BRIGHT;
        ST_BRIGHT:
          state_d = (win_avg <= DARK_LVL) ? ST_DARK : ST_BRIGHT;
        ST_DARK:
          state_d = (win_avg >= BRT_LVL) ? ST_BRIGHT : ST_DARK;
        default:
          state_d = ST_DARK;
      endcase
    end
    dark_d = (state_d == ST_DARK);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      idle_q  <= '0;
      fault_q <= 1'b0;
      dark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      fault_q <= fault_d;
      dark_q  <= dark_d;
    end
  end

  assign bus.Dark         = dark_q;
  assign bus.Sensor_fault = fault_q;

endmodule

// File: tb/tb_lum_sensor_filter.sv
// Scoreboard bench for lum_sensor_filter: window averages,
// hysteresis, timeout fault and reset behaviour.
module tb_lum_sensor_filter;

  typedef int win_t [8];

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   model_state;
  int   last_lum;
  logic [8:0] exp_q [$];

  lum_sensor_filter_if #(.DATA_W(8)) bus ();

  lum_sensor_filter dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (bus.Lum_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL lum_valid_extra got Lum_sen=%0d Dark=%0b want no pulse",
                 bus.Lum_sen, bus.Dark);
      end else begin
        e = exp_q.pop_front();
        if ({bus.Dark, bus.Lum_sen} !== e) begin
          miscompares++;
          $display("FAIL window got Lum_sen=%0d Dark=%0b want Lum_sen=%0d Dark=%0b",
                   bus.Lum_sen, bus.Dark, e[7:0], e[8]);
        end
      end
    end
  end

  function automatic win_t flat(input int v);
    win_t w;
    foreach (w[i]) w[i] = v;
    return w;
  endfunction

  task automatic send(input int d, input int gap);
    bus.Adc_data  = 8'(d);
    bus.Adc_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.Adc_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.Adc_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic win(input win_t s, input int gap);
    int sum;
    int avg;
    sum = 0;
    foreach (s[i]) sum += s[i];
    avg = sum / 8;
    if (avg <= 40 && model_state != 2) model_state = 2;
    else if (avg >= 60 && model_state == 2) model_state = 1;
    else if (model_state == 0) model_state = 1;
    last_lum = avg;
    exp_q.push_back({model_state == 2, 8'(avg)});
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic chk_zero(input string name);
    vectors++;
    if ({bus.Lum_sen, bus.Lum_valid, bus.Dark, bus.Sensor_fault} !== 11'd0) begin
      miscompares++;
      $display("FAIL %s got Lum_sen=%0d Lum_valid=%0b Dark=%0b fault=%0b want all 0",
               name, bus.Lum_sen, bus.Lum_valid, bus.Dark, bus.Sensor_fault);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    model_state = 0;
    last_lum = 0;
  endtask

  task automatic test_basic();
    win(flat(90), 0);
    vectors++;
    if (bus.Sensor_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_fault got %0b want 0", bus.Sensor_fault);
    end
  endtask

  task automatic test_floor_and_max();
    win('{20, 20, 20, 20, 20, 20, 20, 23}, 0);
    win(flat(255), 0);
  endtask

  task automatic test_hysteresis();
    win(flat(20), 0);
    win(flat(50), 1);
    win(flat(60), 0);
    win(flat(41), 2);
    win(flat(40), 0);
  endtask

  task automatic test_gapped();
    win(flat(90), 10);
    vectors++;
    if (bus.Sensor_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_fault got %0b want 0", bus.Sensor_fault);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) send(200, 0);
    repeat (254) @(posedge clk);
    #1;
    vectors++;
    if (bus.Sensor_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_early got %0b want 0 at idle 254", bus.Sensor_fault);
    end
    @(posedge clk);
    #1;
    model_state = 2;
    vectors++;
    if ({bus.Sensor_fault, bus.Dark, bus.Lum_sen} !== {2'b11, 8'(last_lum)}) begin
      miscompares++;
      $display("FAIL fault_set got fault=%0b Dark=%0b Lum_sen=%0d want 1 1 %0d",
               bus.Sensor_fault, bus.Dark, bus.Lum_sen, last_lum);
    end
    exp_q.push_back({1'b0, 8'd90});
    model_state = 1;
    last_lum = 90;
    send(90, 0);
    vectors++;
    if (bus.Sensor_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_clear got %0b want 0", bus.Sensor_fault);
    end
    for (int i = 0; i < 7; i++) send(90, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) send(200, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("reset_mid");
    rst_n = 1'b1;
    model_state = 0;
    win(flat(10), 0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    model_state   = 0;
    last_lum      = 0;
    rst_n         = 1'b0;
    bus.Adc_valid = 1'b0;
    bus.Adc_data  = '0;
    test_reset();
    test_basic();
    test_floor_and_max();
    test_hysteresis();
    test_gapped();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_pulses got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
